// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage.
//
// Issues word-addressed read requests to instruction memory, registers the
// returned instruction together with its address, and handles downstream
// stalls and taken-branch redirects.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   branch            taken-branch request (honoured only while instr_valid=1)
//   offset_in         signed word offset, relative to pc_out + 1
//   stall             downstream hazard: freeze PC and held instruction
//   imem_req/addr     instruction-memory request and word address
//   imem_ack/rdata    memory response for the pending request
//   instr, pc_out     registered instruction and its word address
//   instr_valid       instr/pc_out are valid
//   flush             one-cycle pulse while a redirect is in progress
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned OFFSET_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch,
  input  logic [OFFSET_W-1:0] offset_in,
  input  logic                stall,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [31:0]         pc_out,
  output logic                flush
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StRedirect
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        valid_q;
  logic        flush_q;

  logic [31:0] offset_ext;
  logic [31:0] target;
  logic        take_branch;

  assign offset_ext = 32'(signed'(offset_in));
  // Unsigned 32-bit add wraps naturally in both directions.
  assign target     = pc_out_q + 32'd1 + offset_ext;

  // A branch only refers to a valid held instruction; HOLD keeps that
  // instruction, so a branch during a stall is still honoured.
  assign take_branch = branch && valid_q && ((state_q == StFetch) || (state_q == StHold));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc_out_q <= 32'd0;
      valid_q  <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        // One dead cycle after reset so a stale response is never captured.
        StIdle: state_q <= StFetch;

        StFetch: begin
          if (take_branch) begin
            pc_q    <= target;
            valid_q <= 1'b0;
            flush_q <= 1'b1;
            state_q <= StRedirect;
          end else if (stall) begin
            // Any ack on this edge is dropped; the same PC is re-requested.
            if (valid_q) state_q <= StHold;
          end else if (imem_ack) begin
            instr_q  <= imem_rdata;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            pc_q     <= pc_q + 32'd1;
          end else begin
            valid_q <= 1'b0;
          end
        end

        StHold: begin
          if (take_branch) begin
            pc_q    <= target;
            valid_q <= 1'b0;
            flush_q <= 1'b1;
            state_q <= StRedirect;
          end else if (!stall) begin
            state_q <= StFetch;
          end
        end

        StRedirect: state_q <= StFetch;

        default: state_q <= StIdle;
      endcase
    end
  end

  // Request is a pure decode of the state register; the address is the PC
  // register, which only moves on an accepted ack or a redirect.
  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [15:0] offset_in;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid, flush;
  logic [31:0] imem_addr, instr, pc_out;

  logic        imem_req2, instr_valid2, flush2;
  logic [31:0] imem_addr2, instr2, pc_out2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .branch     (branch),
    .offset_in  (offset_in),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .flush      (flush)
  );

  // Second instance exercises a reset address near the top of the space.
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_top (
    .clk        (clk),
    .rst        (rst),
    .branch     (branch),
    .offset_in  (offset_in),
    .stall      (stall),
    .imem_req   (imem_req2),
    .imem_addr  (imem_addr2),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr2),
    .instr_valid(instr_valid2),
    .pc_out     (pc_out2),
    .flush      (flush2)
  );

  // ---------------------------------------------------------------------
  // Reference model: architectural view of the fetch stage.
  // ---------------------------------------------------------------------
  localparam int PhStartup = 0, PhRequesting = 1, PhFrozen = 2, PhRedirecting = 3;
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_flush;

  function automatic void model_reset();
    m_phase = PhStartup;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pcout = 32'h0;
    m_valid = 1'b0;
    m_flush = 1'b0;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  function automatic void model_step();
    logic [31:0] tgt;
    bit          redirect;
    tgt      = 32'(longint'(m_pcout) + 1 + longint'($signed(offset_in)));
    redirect = branch && m_valid && (m_phase == PhRequesting || m_phase == PhFrozen);
    m_flush  = 1'b0;
    if (redirect) begin
      m_pc    = tgt;
      m_valid = 1'b0;
      m_flush = 1'b1;
      m_phase = PhRedirecting;
    end else if (m_phase == PhStartup || m_phase == PhRedirecting) begin
      m_phase = PhRequesting;
    end else if (m_phase == PhFrozen) begin
      if (!stall) m_phase = PhRequesting;
    end else if (stall) begin
      if (m_valid) m_phase = PhFrozen;
    end else if (imem_ack) begin
      m_instr = imem_rdata;
      m_pcout = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 1;
    end else begin
      m_valid = 1'b0;
    end
  endfunction

  // ---------------------------------------------------------------------
  // Cycle helpers: inputs change at posedge+1, outputs sampled at negedge.
  // ---------------------------------------------------------------------
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    branch = 1'b0; stall = 1'b0; imem_ack = 1'b0; offset_in = 16'h0; imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_stream();
    imem_ack   = 1'b1;
    imem_rdata = imem_addr + 32'd100;
  endtask

  // Ends at the start of the cycle where pc_out=4, instr=104, imem_addr=5.
  task automatic run_to_pc4();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive_stream();
      advance();
    end
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0h want=0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%0h want=0", imem_addr); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%0h want=0", instr); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out got=%0h want=0", pc_out); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h want=0", instr_valid); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%0h want=0", flush); end
    n_checks++; if (imem_addr2 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL reset_addr_top got=%0h want=fffffffe", imem_addr2); end
    do_reset();
    // Idle cycle: a response here must not be captured.
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%0h want=0", imem_req); end
    advance();
    sample();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got=%0h want=1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got=%0h want=0", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_capture got=%0h want=0", instr_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      drive_stream();
      sample();
      if (c >= 1) begin
        n_checks++; if (imem_addr !== 32'(c - 1)) begin n_fail++; $display("FAIL stream_addr c=%0d got=%0h want=%0h", c, imem_addr, c - 1); end
      end
      if (c >= 2) begin
        n_checks++; if (instr !== 32'(100 + c - 2)) begin n_fail++; $display("FAIL stream_instr c=%0d got=%0d want=%0d", c, instr, 100 + c - 2); end
        n_checks++; if (pc_out !== 32'(c - 2)) begin n_fail++; $display("FAIL stream_pc_out c=%0d got=%0d want=%0d", c, pc_out, c - 2); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c=%0d got=%0h want=1", c, instr_valid); end
      end
      advance();
    end
  endtask

  task automatic test_branch(input logic [15:0] off, input logic [31:0] want_addr);
    run_to_pc4();
    drive_stream();
    branch = 1'b1; offset_in = off;
    sample();
    n_checks++; if (pc_out !== 32'd4) begin n_fail++; $display("FAIL br_setup_pc_out got=%0d want=4", pc_out); end
    advance();
    branch = 1'b0;
    drive_stream();
    sample();
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush got=%0h want=1", flush); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid got=%0h want=0", instr_valid); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL br_req got=%0h want=0", imem_req); end
    advance();
    drive_stream();
    sample();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_flush_pulse got=%0h want=0", flush); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL br_refetch_req got=%0h want=1", imem_req); end
    n_checks++; if (imem_addr !== want_addr) begin n_fail++; $display("FAIL br_target off=%0h got=%0h want=%0h", off, imem_addr, want_addr); end
    advance();
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive_stream();
      advance();
    end
    // Cycle 3: instr=101 valid at pc_out=1, PC=2. Stall for three cycles.
    for (int c = 3; c <= 5; c++) begin
      drive_stream();
      stall = 1'b1;
      sample();
      if (c >= 4) begin
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req c=%0d got=%0h want=0", c, imem_req); end
        n_checks++; if (instr !== 32'd101) begin n_fail++; $display("FAIL stall_instr c=%0d got=%0d want=101", c, instr); end
        n_checks++; if (pc_out !== 32'd1) begin n_fail++; $display("FAIL stall_pc_out c=%0d got=%0d want=1", c, pc_out); end
        n_checks++; if (imem_addr !== 32'd2) begin n_fail++; $display("FAIL stall_pc c=%0d got=%0d want=2", c, imem_addr); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c=%0d got=%0h want=1", c, instr_valid); end
      end
      advance();
    end
    stall = 1'b0;
    drive_stream();
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL unstall_req got=%0h want=0", imem_req); end
    advance();
    drive_stream();
    sample();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL resume_req got=%0h want=1", imem_req); end
    n_checks++; if (imem_addr !== 32'd2) begin n_fail++; $display("FAIL resume_addr got=%0d want=2", imem_addr); end
    advance();
    drive_stream();
    sample();
    n_checks++; if (instr !== 32'd102) begin n_fail++; $display("FAIL resume_instr got=%0d want=102", instr); end
    n_checks++; if (pc_out !== 32'd2) begin n_fail++; $display("FAIL resume_pc_out got=%0d want=2", pc_out); end
    advance();
  endtask

  task automatic test_branch_stall_ack();
    run_to_pc4();
    branch = 1'b1; stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; offset_in = 16'd3;
    advance();
    idle_inputs();
    sample();
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL bsa_flush got=%0h want=1", flush); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bsa_valid got=%0h want=0", instr_valid); end
    n_checks++; if (instr !== 32'd104) begin n_fail++; $display("FAIL bsa_discard got=%0h want=68", instr); end
    advance();
    sample();
    n_checks++; if (imem_addr !== 32'd8) begin n_fail++; $display("FAIL bsa_target got=%0d want=8", imem_addr); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bsa_req got=%0h want=1", imem_req); end
    advance();
  endtask

  task automatic test_ignore_branch();
    run_to_pc4();
    imem_ack = 1'b0;
    advance();
    branch = 1'b1; offset_in = 16'd10;
    sample();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got=%0h want=0", instr_valid); end
    n_checks++; if (imem_addr !== 32'd5) begin n_fail++; $display("FAIL bubble_pc got=%0d want=5", imem_addr); end
    advance();
    branch = 1'b0;
    sample();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL ign_br_flush got=%0h want=0", flush); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ign_br_req got=%0h want=1", imem_req); end
    n_checks++; if (imem_addr !== 32'd5) begin n_fail++; $display("FAIL ign_br_addr got=%0d want=5", imem_addr); end
    advance();
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0000_0000;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      drive_stream();
      sample();
      if (c >= 1) begin
        n_checks++; if (imem_addr2 !== want[c-1]) begin n_fail++; $display("FAIL wrap_addr c=%0d got=%0h want=%0h", c, imem_addr2, want[c-1]); end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive_stream();
      advance();
    end
    drive_stream();
    sample();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_req got=%0h want=0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_addr got=%0h want=0", imem_addr); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL arst_instr got=%0h want=0", instr); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL arst_pc_out got=%0h want=0", pc_out); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%0h want=0", instr_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_idle_req got=%0h want=0", imem_req); end
    advance();
    sample();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL arst_first_req got=%0h want=1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_first_addr got=%0h want=0", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_capture got=%0h want=0", instr_valid); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      branch     = ($urandom_range(0, 7) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      imem_ack   = ($urandom_range(0, 3) != 0);
      offset_in  = 16'($urandom);
      imem_rdata = $urandom;
      sample();
      n_checks++; if (imem_req !== (m_phase == PhRequesting)) begin n_fail++; $display("FAIL rnd_req c=%0d got=%0h want=%0h", c, imem_req, (m_phase == PhRequesting)); end
      n_checks++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%0h want=%0h", c, imem_addr, m_pc); end
      n_checks++; if (instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr c=%0d got=%0h want=%0h", c, instr, m_instr); end
      n_checks++; if (pc_out !== m_pcout) begin n_fail++; $display("FAIL rnd_pc_out c=%0d got=%0h want=%0h", c, pc_out, m_pcout); end
      n_checks++; if (instr_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%0h want=%0h", c, instr_valid, m_valid); end
      n_checks++; if (flush !== m_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d got=%0h want=%0h", c, flush, m_flush); end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_branch(16'd10, 32'd15);
    test_branch(16'hFFFA, 32'hFFFF_FFFF);
    test_stall();
    test_branch_stall_ack();
    test_ignore_branch();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
